// File: rtl/uart_tx_feeder_if.sv
// Write port and transmitter-side handshake of the UART TX feeder.
// The slave modport is the feeder's view; the master modport is the surrounding logic's view.
interface uart_tx_feeder_if;
  logic       i_Wr_DV;
  logic [7:0] i_Wr_Byte;
  logic       o_Wr_Ready;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       i_TX_Active;
  logic       i_TX_Done;

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
    output o_Wr_Ready, o_TX_DV, o_TX_Byte
  );

  modport master (
    output i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
    input  o_Wr_Ready, o_TX_DV, o_TX_Byte
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus issue engine: pops one byte at a time into the UART transmitter,
// waits for its done pulse and optionally idles GAP_CLKS clocks before the next issue.
module uart_tx_feeder #(
  parameter  int DEPTH    = 16,
  parameter  int GAP_CLKS = 0,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                i_Clock,
  input  logic                i_Rst,
  uart_tx_feeder_if.slave     tx_if,
  output logic [CW-1:0]       o_Count,
  output logic                o_Empty,
  output logic                o_Busy,
  output logic                o_Overflow,
  input  logic                i_Clr_Overflow
);

  localparam int PW       = $clog2(DEPTH);
  localparam int GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int GAP_LOAD = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_FETCH       = 3'd1;
  localparam logic [2:0] S_WAIT_ACTIVE = 3'd2;
  localparam logic [2:0] S_WAIT_DONE   = 3'd3;
  localparam logic [2:0] S_GAP         = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    tx_byte_q;
  logic          tx_dv_q;
  logic          ovf_q;
  logic          wr_ready, wr_fire, wr_reject, pop;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ready  = (count_q != CW'(DEPTH));
    wr_fire   = tx_if.i_Wr_DV & wr_ready;
    wr_reject = tx_if.i_Wr_DV & ~wr_ready;
    pop       = (state_q == S_IDLE) && (count_q != '0) && !tx_if.i_TX_Active;

    count_d = count_q;
    case ({wr_fire, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT_ACTIVE;
      S_WAIT_ACTIVE, S_WAIT_DONE: begin
        // A done pulse that beats the active flag still completes the byte.
        if (tx_if.i_TX_Done) begin
          if (GAP_CLKS == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = GW'(GAP_LOAD);
          end
        end else if (state_q == S_WAIT_ACTIVE && tx_if.i_TX_Active) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      gap_q     <= '0;
      tx_byte_q <= '0;
      tx_dv_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      state_q <= state_d;
      gap_q   <= gap_d;
      tx_dv_q <= (state_q == S_FETCH);
      if (state_q == S_FETCH) tx_byte_q <= rd_data_q;
      if (wr_reject)           ovf_q <= 1'b1;
      else if (i_Clr_Overflow) ovf_q <= 1'b0;
    end
  end

  // NOTE: the storage array and its read register carry no reset; the pointers and count define what is valid.
  always_ff @(posedge i_Clock) begin
    if (wr_fire) mem[wr_ptr_q] <= tx_if.i_Wr_Byte;
    if (pop)     rd_data_q     <= mem[rd_ptr_q];
  end

  assign tx_if.o_Wr_Ready = wr_ready;
  assign tx_if.o_TX_DV    = tx_dv_q;
  assign tx_if.o_TX_Byte  = tx_byte_q;
  assign o_Count          = count_q;
  assign o_Empty          = (count_q == '0);
  assign o_Busy           = (state_q != S_IDLE) || (count_q != '0);
  assign o_Overflow       = ovf_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench: a transmitter model plus an expected-byte queue score instance A (GAP_CLKS=0);
// a second instance with GAP_CLKS=5 is driven by hand to measure issue spacing.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BCW   = $clog2(4) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clr_ovf;
  logic [CW-1:0]  a_count;
  logic           a_empty, a_busy, a_ovf;
  logic [BCW-1:0] b_count;
  logic           b_empty, b_busy, b_ovf;

  uart_tx_feeder_if a_if ();
  uart_tx_feeder_if b_if ();

  uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CLKS(0)) dut_a (
    .i_Clock(clk), .i_Rst(rst), .tx_if(a_if.slave),
    .o_Count(a_count), .o_Empty(a_empty), .o_Busy(a_busy),
    .o_Overflow(a_ovf), .i_Clr_Overflow(clr_ovf)
  );

  uart_tx_feeder #(.DEPTH(4), .GAP_CLKS(5)) dut_b (
    .i_Clock(clk), .i_Rst(rst), .tx_if(b_if.slave),
    .o_Count(b_count), .o_Empty(b_empty), .o_Busy(b_busy),
    .o_Overflow(b_ovf), .i_Clr_Overflow(1'b0)
  );

  logic model_active = 1'b0;
  logic model_done   = 1'b0;
  logic force_active = 1'b0;
  assign a_if.i_TX_Active = model_active | force_active;
  assign a_if.i_TX_Done   = model_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int issued = 0;
  int frame_clks = 20;
  int inv_bad = 0;
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [7:0] d, input bit accept);
    a_if.i_Wr_DV   = 1'b1;
    a_if.i_Wr_Byte = d;
    if (accept) exp_q.push_back(d);
    tick();
    a_if.i_Wr_DV = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || a_busy || model_active || model_done) && n < budget) begin
      tick();
      n++;
    end
    check("drain_within_budget", 32'(n < budget), 32'd1);
  endtask

  // Occupancy-derived flags must track the count on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_if.o_Wr_Ready !== (a_count != CW'(DEPTH))) inv_bad++;
      if (a_empty !== (a_count == '0)) inv_bad++;
      if (a_count > CW'(DEPTH)) inv_bad++;
    end
  end

  // Transmitter model: a frame of frame_clks busy clocks then a done pulse; every issue is scored.
  initial begin
    logic dv_busy;
    forever begin
      @(negedge clk);
      if (a_if.o_TX_DV === 1'b1) begin
        issued++;
        if (exp_q.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
        else                   check("tx_byte", 32'(a_if.o_TX_Byte), 32'(exp_q.pop_front()));
        model_active = 1'b1;
        @(negedge clk);
        check("dv_one_cycle", 32'(a_if.o_TX_DV), 32'd0);
        dv_busy = 1'b0;
        repeat (frame_clks - 1) begin
          @(negedge clk);
          if (a_if.o_TX_DV) dv_busy = 1'b1;
        end
        model_active = 1'b0;
        model_done   = 1'b1;
        @(negedge clk);
        if (a_if.o_TX_DV) dv_busy = 1'b1;
        model_done = 1'b0;
        check("no_dv_while_busy", 32'(dv_busy), 32'd0);
      end
    end
  end

  initial begin
    int base;
    int accepted;
    int n;
    int dv_edge;
    int done_edge;

    rst = 1'b1;
    clr_ovf = 1'b0;
    a_if.i_Wr_DV = 1'b0;
    a_if.i_Wr_Byte = 8'h00;
    b_if.i_Wr_DV = 1'b0;
    b_if.i_Wr_Byte = 8'h00;
    b_if.i_TX_Active = 1'b0;
    b_if.i_TX_Done = 1'b0;
    repeat (3) tick();

    check("rst_tx_dv",    32'(a_if.o_TX_DV),    32'd0);
    check("rst_tx_byte",  32'(a_if.o_TX_Byte),  32'd0);
    check("rst_count",    32'(a_count),         32'd0);
    check("rst_empty",    32'(a_empty),         32'd1);
    check("rst_wr_ready", 32'(a_if.o_Wr_Ready), 32'd1);
    check("rst_busy",     32'(a_busy),          32'd0);
    check("rst_overflow", 32'(a_ovf),           32'd0);
    rst = 1'b0;
    tick();

    // Single byte latency: accepted at edge k, pulse in the cycle after edge k+2.
    frame_clks = 20;
    write_a(8'hA5, 1'b1);
    check("lat_count_k",   32'(a_count), 32'd1);
    tick();
    check("lat_dv_k1",     32'(a_if.o_TX_DV), 32'd0);
    check("lat_count_k1",  32'(a_count), 32'd0);
    tick();
    check("lat_dv_k2",     32'(a_if.o_TX_DV), 32'd1);
    check("lat_byte_k2",   32'(a_if.o_TX_Byte), 32'hA5);
    tick();
    check("lat_dv_k3",     32'(a_if.o_TX_DV), 32'd0);
    check("busy_in_frame", 32'(a_busy), 32'd1);
    wait_drain(200);
    check("busy_after_done", 32'(a_busy), 32'd0);

    // Back-to-back burst with a 50-clocks-per-bit frame.
    frame_clks = 500;
    base = issued;
    for (int i = 0; i < 16; i++) write_a(8'(i), 1'b1);
    wait_drain(20000);
    check("burst_issued", 32'(issued - base), 32'd16);
    check("burst_no_ovf", 32'(a_ovf), 32'd0);

    // Fill with the transmitter held busy, then overflow handling.
    frame_clks = 20;
    force_active = 1'b1;
    for (int i = 0; i < 16; i++) write_a(8'h40 + 8'(i), 1'b1);
    check("full_count", 32'(a_count), 32'd16);
    check("full_ready", 32'(a_if.o_Wr_Ready), 32'd0);
    write_a(8'h77, 1'b0);
    check("ovf_set",   32'(a_ovf), 32'd1);
    check("ovf_count", 32'(a_count), 32'd16);
    repeat (2) tick();
    check("ovf_sticky", 32'(a_ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(a_ovf), 32'd0);
    clr_ovf = 1'b1;
    write_a(8'h78, 1'b0);
    clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(a_ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    force_active = 1'b0;
    write_a(8'h79, 1'b0);
    check("pop_no_rescue_count", 32'(a_count), 32'd15);
    check("pop_no_rescue_ovf",   32'(a_ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    wait_drain(2000);

    // Simultaneous write and pop at DEPTH-1.
    force_active = 1'b1;
    for (int i = 0; i < 15; i++) write_a(8'h60 + 8'(i), 1'b1);
    check("pre_simul_count", 32'(a_count), 32'd15);
    force_active = 1'b0;
    write_a(8'h6F, 1'b1);
    check("simul_count", 32'(a_count), 32'd15);
    wait_drain(2000);

    // Reset while the transmitter is mid-frame with three bytes still queued.
    frame_clks = 100;
    for (int i = 0; i < 4; i++) write_a(8'h90 + 8'(i), 1'b1);
    repeat (3) tick();
    check("pre_rst_count", 32'(a_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_count", 32'(a_count), 32'd0);
    check("mid_rst_empty", 32'(a_empty), 32'd1);
    check("mid_rst_dv",    32'(a_if.o_TX_DV), 32'd0);
    check("mid_rst_busy",  32'(a_busy), 32'd0);
    wait_drain(300);
    base = issued;
    write_a(8'hC3, 1'b1);
    wait_drain(300);
    check("post_rst_issue", 32'(issued - base), 32'd1);

    // Randomized traffic with varying frame lengths; pointers wrap many times.
    base = issued;
    accepted = 0;
    for (int i = 0; i < 300; i++) begin
      if (i % 16 == 0) frame_clks = $urandom_range(3, 30);
      if ($urandom_range(0, 2) != 0 && a_if.o_Wr_Ready) begin
        write_a(8'($urandom), 1'b1);
        accepted++;
      end else begin
        tick();
      end
    end
    wait_drain(10000);
    check("rand_issued", 32'(issued - base), 32'(accepted));
    check("rand_no_ovf", 32'(a_ovf), 32'd0);
    check("final_count", 32'(a_count), 32'd0);
    check("flag_invariants", 32'(inv_bad), 32'd0);

    // GAP_CLKS=5 instance: next issue exactly 7 clocks after the done edge.
    b_if.i_Wr_DV = 1'b1;
    b_if.i_Wr_Byte = 8'hD1;
    tick();
    b_if.i_Wr_Byte = 8'hD2;
    tick();
    b_if.i_Wr_DV = 1'b0;
    n = 0;
    while (!b_if.o_TX_DV && n < 20) begin tick(); n++; end
    check("gap_first_issue", 32'(b_if.o_TX_DV), 32'd1);
    check("gap_first_byte",  32'(b_if.o_TX_Byte), 32'hD1);
    tick();
    b_if.i_TX_Active = 1'b1;
    repeat (5) tick();
    b_if.i_TX_Active = 1'b0;
    b_if.i_TX_Done = 1'b1;
    done_edge = cyc + 1;
    tick();
    b_if.i_TX_Done = 1'b0;
    n = 0;
    while (!b_if.o_TX_DV && n < 20) begin tick(); n++; end
    dv_edge = cyc;
    check("gap_second_issue", 32'(b_if.o_TX_DV), 32'd1);
    check("gap_spacing",      32'(dv_edge - done_edge), 32'd7);
    check("gap_second_byte",  32'(b_if.o_TX_Byte), 32'hD2);
    tick();
    b_if.i_TX_Done = 1'b1;
    tick();
    b_if.i_TX_Done = 1'b0;
    repeat (4) tick();
    check("gap_busy_hold", 32'(b_busy), 32'd1);
    repeat (2) tick();
    check("gap_busy_drop", 32'(b_busy), 32'd0);
    check("gap_b_no_ovf",  32'(b_ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
